reg_file_mp: RTL
================

Name: reg_file_mp

Overview:
- Parametrised multi-read-port register file; next generation of the datapath register file.
- Sits between decode (read addresses) and writeback (write port); feeds operand registers to the ALU stage.
- Adds over the previous block:
  - configurable width, depth and read-port count
  - per-port read enable and valid
  - selectable same-cycle write-to-read bypass
  - optional hardwired zero register
  - hardware clear sweep after reset or on request

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 6, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of independent read ports (1..4)
BYPASS, 0, 1 = read of address being written this cycle returns new data; 0 = returns old data
ZERO_REG, 0, 1 = entry 0 reads as zero and ignores writes

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
clr_req  in  1  request to zero all entries (one-cycle pulse)
busy  out  1  high while clear sweep runs
wr_en  in  1  write enable
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_en  in  NUM_RD  per-port read enable
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed registered read data; port i at [i*DATA_W +: DATA_W]
rd_valid  out  NUM_RD  per-port pulse: rd_data for port i updated this cycle

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset asserted:
  - state = SWEEP, sweep pointer = 0
  - rd_data = 0, rd_valid = 0, busy = 1
  - Storage array is not reset directly; the sweep zeroes it.
- FSM states: SWEEP, IDLE.
- SWEEP:
  - Each cycle writes 0 to mem[ptr], then ptr increments.
  - After writing ptr = DEPTH-1, next state is IDLE.
  - Sweep lasts exactly DEPTH cycles after rst_n deasserts; busy is high throughout and drops on the first IDLE cycle.
- IDLE with clr_req = 1: next state SWEEP, ptr = 0. A write in the same cycle is still performed and is then swept.
- clr_req during SWEEP is ignored; the sweep does not restart.
- Reset asserted mid-sweep: sweep restarts from ptr = 0 on release.
- During busy:
  - wr_en is ignored.
  - rd_en is ignored: rd_valid = 0 and rd_data holds.
- Write:
  - In IDLE with wr_en = 1, mem[wr_addr] <= wr_data at the rising edge.
  - With ZERO_REG = 1 and wr_addr = 0, the write is dropped.
- Read, per port i, independent:
  - Latency 1. rd_en[i] = 1 in cycle N gives rd_data[i] = mem[rd_addr[i]] and rd_valid[i] = 1 in cycle N+1.
  - rd_en[i] = 0: rd_data[i] holds its last value and rd_valid[i] = 0.
- Same-cycle read/write to the same address:
  - BYPASS = 1: rd_data gets wr_data.
  - BYPASS = 0: rd_data gets the pre-write contents.
  - Dropped writes (busy, or ZERO_REG address 0) never bypass.
- ZERO_REG = 1: a read of address 0 returns 0 regardless of storage.
- Multiple ports reading the same address in the same cycle all return identical data.
- Addresses are always in range (DEPTH = 2**ADDR_W), so no out-of-range handling is needed.

Decomposition:
- Package reg_file_pkg holds:
  - state enum (SWEEP, IDLE)
  - default parameter constants (DATA_W = 32, ADDR_W = 6, NUM_RD = 2)
  - helper function for packed-slice indexing
- One sub-module, rf_read_port, generated NUM_RD times. It contains:
  - registered rd_data/rd_valid
  - bypass compare
  - zero-register mux
- Storage, write logic and FSM stay in reg_file_mp.

Test Plan:
- Reset sequence (defaults): deassert rst_n -> busy = 1 for exactly 64 cycles, then 0; reading entries 0..63 afterward returns 0 with rd_valid pulsing one cycle after each rd_en.
- Basic write/read: write reg10 = 2, reg11 = 6; next cycle rd_addr port0 = 10, port1 = 11 with rd_en = 2'b11 -> one cycle later rd_data port0 = 2, port1 = 6, rd_valid = 2'b11.
- Same-cycle hazard: reg5 holds 0x11; write reg5 = 0xAA while port0 reads 5 -> returns 0xAA with BYPASS = 1, 0x11 with BYPASS = 0; a following read returns 0xAA in both.
- Zero register (ZERO_REG = 1): write reg0 = 0xDEAD -> read reg0 returns 0, no bypass.
- Clear request: fill reg3 = 7, pulse clr_req together with a write reg4 = 9 -> busy high 64 cycles; writes and reads during busy are ignored (rd_valid = 0, rd_data holds); afterward reg3 = 0, reg4 = 0.
- Reset mid-sweep: assert rst_n low at sweep cycle 20, release -> busy high a full 64 cycles again; all entries read 0 afterward.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared state type, default sizes and packed-slice helper for reg_file_mp
package reg_file_pkg;
    typedef enum logic {SWEEP, IDLE} state_t;
    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 6;
    localparam int RF_NUM_RD = 2;
    function automatic int lsb(input int idx, input int w);
        return idx * w;
    endfunction
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one registered read port with write bypass and zero-register mux
module rf_read_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 6,
    parameter int BYPASS   = 0,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_ok,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);
    logic [DATA_W-1:0] nxt;
    logic              hit;
    always_comb begin
        hit = BYPASS != 0 && wr_ok && wr_addr == addr;
        nxt = (ZERO_REG != 0 && addr == '0) ? '0 : hit ? wr_data : mem_data;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= en;
            if (en) rd_data <= nxt;
        end
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-read-port register file with clear sweep after reset or on request
module reg_file_mp import reg_file_pkg::*; #(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int BYPASS   = 0,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_req,
    output logic                     busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid
);
    localparam int DEPTH = 2 ** ADDR_W;
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= SWEEP;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= (state == SWEEP) ? ptr + 1'b1 : '0;
        end
    always_comb
        state_nxt = (state == SWEEP) ? ((&ptr) ? IDLE : SWEEP) : (clr_req ? SWEEP : IDLE);
    always_comb begin
        busy  = state == SWEEP;
        wr_ok = !busy && wr_en && !(ZERO_REG != 0 && wr_addr == '0);
    end
    // storage is cleared only by the sweep, never by reset
    always_ff @(posedge clk)
        if (busy) mem[ptr] <= '0;
        else if (wr_ok) mem[wr_addr] <= wr_data;
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = rd_addr[lsb(i, ADDR_W) +: ADDR_W];
        rf_read_port #(
            .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
        ) u_port (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (rd_en[i] && !busy),
            .addr     (a),
            .wr_ok    (wr_ok),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .mem_data (mem[a]),
            .rd_data  (rd_data[lsb(i, DATA_W) +: DATA_W]),
            .rd_valid (rd_valid[i])
        );
    end
endmodule
